nth_band_predictor: RTL and testbench

- Inter-band predictor for the LCPLC hyperspectral compressor; used for every band after the first.
- Each sample is predicted from the co-located reconstructed sample of the previous band (xhat), the previous band's block mean (xhatmean), the current band's block mean (xmean) and a per-block scaling factor (alpha).
- All inputs and the output are AXI-Stream-style valid/ready channels.
- Feeds the residual/coding stage.

---
 rtl/nth_band_predictor.sv | 119 +++++++++++
 tb/tb_nth_band_predictor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nth_band_predictor.sv
// Inter-band predictor: scales the previous band's mean-removed sample by alpha and
// re-centres it on the current band's block mean, over a 3-stage elastic pipeline.
module nth_band_predictor #(
  parameter int DATA_WIDTH     = 16,
  parameter int ALPHA_WIDTH    = 10,
  parameter int BLOCK_SIZE_LOG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    xhat_valid,
  output logic                    xhat_ready,
  input  logic [DATA_WIDTH-1:0]   xhat_data,
  input  logic                    xmean_valid,
  output logic                    xmean_ready,
  input  logic [DATA_WIDTH-1:0]   xmean_data,
  input  logic                    xhatmean_valid,
  output logic                    xhatmean_ready,
  input  logic [DATA_WIDTH-1:0]   xhatmean_data,
  input  logic                    alpha_valid,
  output logic                    alpha_ready,
  input  logic [ALPHA_WIDTH-1:0]  alpha_data,
  output logic                    prediction_valid,
  input  logic                    prediction_ready,
  output logic [DATA_WIDTH:0]     prediction_data
);
  localparam int DW1 = DATA_WIDTH + 1;
  localparam int PW  = DATA_WIDTH + ALPHA_WIDTH + 2;
  localparam int RW  = PW + 1;

  logic [BLOCK_SIZE_LOG-1:0] cnt_q;
  logic                      v1_q, v2_q, v3_q;
  logic signed [DW1-1:0]     d_q;
  logic [ALPHA_WIDTH-1:0]    alpha1_q;
  logic [DATA_WIDTH-1:0]     xmean1_q, xmean2_q;
  logic signed [PW-1:0]      p_q;
  logic [DATA_WIDTH:0]       pred_q;

  logic adv1, adv2, adv3, all_valid, last, fire;

  // A stage may load when it is empty or its contents leave in the same cycle.
  assign adv3      = !v3_q || prediction_ready;
  assign adv2      = !v2_q || adv3;
  assign adv1      = !v1_q || adv2;
  assign all_valid = xhat_valid && xmean_valid && xhatmean_valid && alpha_valid;
  assign last      = (cnt_q == '1);
  assign fire      = rst && all_valid && adv1;

  assign xhat_ready     = fire;
  assign xmean_ready    = fire && last;
  assign xhatmean_ready = fire && last;
  assign alpha_ready    = fire && last;

  assign prediction_valid = v3_q;
  assign prediction_data  = pred_q;

  logic signed [DW1-1:0]   d_d;
  logic signed [ALPHA_WIDTH:0] alpha_s;
  logic signed [PW-1:0]    p_d;
  logic signed [PW-1:0]    s_d;
  logic signed [RW-1:0]    r_d;
  logic                    r_fits;
  logic [DATA_WIDTH:0]     sat_d;

  assign d_d     = $signed({1'b0, xhat_data}) - $signed({1'b0, xhatmean_data});
  assign alpha_s = $signed({1'b0, alpha1_q});
  assign p_d     = PW'(alpha_s) * PW'(d_q);
  assign s_d     = p_q >>> (ALPHA_WIDTH - 1);
  assign r_d     = RW'(s_d) + RW'($signed({1'b0, xmean2_q}));

  // r fits the signed output iff every bit above the output sign bit matches it.
  assign r_fits = (r_d[RW-1:DATA_WIDTH] == '0) || (r_d[RW-1:DATA_WIDTH] == '1);

  always_comb begin
    sat_d = r_d[DATA_WIDTH:0];
    if (!r_fits) begin
      sat_d = r_d[RW-1] ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, {DATA_WIDTH{1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      d_q      <= '0;
      alpha1_q <= '0;
      xmean1_q <= '0;
      xmean2_q <= '0;
      p_q      <= '0;
      pred_q   <= '0;
    end else begin
      if (fire) begin
        cnt_q <= cnt_q + BLOCK_SIZE_LOG'(1);
      end
      if (adv1) begin
        v1_q <= fire;
        if (fire) begin
          d_q      <= d_d;
          alpha1_q <= alpha_data;
          xmean1_q <= xmean_data;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          p_q      <= p_d;
          xmean2_q <= xmean1_q;
        end
      end
      if (adv3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          pred_q <= sat_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_nth_band_predictor.sv
// Randomized scoreboard bench for nth_band_predictor: a driver pushes reference
// predictions on each xhat transfer, an independent monitor pops them on each output.
module tb_nth_band_predictor;
  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int BL  = 8;
  localparam int BLK = 1 << BL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          xhat_valid = 1'b0, xhat_ready;
  logic [DW-1:0] xhat_data = '0;
  logic          xmean_valid = 1'b0, xmean_ready;
  logic [DW-1:0] xmean_data = '0;
  logic          xhatmean_valid = 1'b0, xhatmean_ready;
  logic [DW-1:0] xhatmean_data = '0;
  logic          alpha_valid = 1'b0, alpha_ready;
  logic [AW-1:0] alpha_data = '0;
  logic          prediction_valid;
  logic          prediction_ready = 1'b1;
  logic [DW:0]   prediction_data;

  nth_band_predictor #(.DATA_WIDTH(DW), .ALPHA_WIDTH(AW), .BLOCK_SIZE_LOG(BL)) dut (
    .clk(clk), .rst(rst),
    .xhat_valid(xhat_valid), .xhat_ready(xhat_ready), .xhat_data(xhat_data),
    .xmean_valid(xmean_valid), .xmean_ready(xmean_ready), .xmean_data(xmean_data),
    .xhatmean_valid(xhatmean_valid), .xhatmean_ready(xhatmean_ready), .xhatmean_data(xhatmean_data),
    .alpha_valid(alpha_valid), .alpha_ready(alpha_ready), .alpha_data(alpha_data),
    .prediction_valid(prediction_valid), .prediction_ready(prediction_ready),
    .prediction_data(prediction_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW:0] data; int cyc; } exp_t;
  typedef struct { int a; int xm; int xhm; } tuple_t;

  exp_t   sb[$];
  tuple_t dir_t[$];
  int     dir_x[$];
  int     n_cmp = 0, n_bad = 0;
  bit     lat_chk = 0, abort = 0;

  tuple_t cur_t;
  int     cur_x = 0, idx = 0;
  bit     have_t = 0, t_on = 0, have_x = 0;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: prediction from the arithmetic rules with integer floor division.
  function automatic logic [DW:0] ref_pred(int a, int xm, int xhm, int x);
    longint d, p, s, r;
    logic [63:0] rv;
    d = longint'(x) - longint'(xhm);
    p = longint'(a) * d;
    if (p >= 0) s = p / 512;
    else        s = -((-p + 511) / 512);
    r = longint'(xm) + s;
    if (r > 65535)  r = 65535;
    if (r < -65536) r = -65536;
    rv = r;
    return rv[DW:0];
  endfunction

  function automatic int rnd(int maxv);
    int k;
    k = $urandom_range(9);
    if (k == 0) return 0;
    if (k == 1) return maxv;
    return $urandom_range(maxv);
  endfunction

  function automatic tuple_t next_tuple();
    tuple_t t;
    if (dir_t.size() != 0) return dir_t.pop_front();
    t.a = rnd(1023); t.xm = rnd(65535); t.xhm = rnd(65535);
    return t;
  endfunction

  function automatic int next_x();
    if (dir_x.size() != 0) return dir_x.pop_front();
    return rnd(65535);
  endfunction

  task automatic run(int n, int pv, int pr);
    int fired = 0, idle = 0;
    bit hx, ha, hm, hh, lastx;
    while (fired < n && !abort) begin
      @(negedge clk);
      if (!have_t) begin cur_t = next_tuple(); have_t = 1; t_on = 0; end
      if (!t_on && $urandom_range(99) < pv) t_on = 1;
      if (!have_x && $urandom_range(99) < pv) begin cur_x = next_x(); have_x = 1; end
      xhat_valid     = have_x;
      xhat_data      = cur_x[DW-1:0];
      alpha_valid    = t_on;  alpha_data    = cur_t.a[AW-1:0];
      xmean_valid    = t_on;  xmean_data    = cur_t.xm[DW-1:0];
      xhatmean_valid = t_on;  xhatmean_data = cur_t.xhm[DW-1:0];
      prediction_ready = ($urandom_range(99) < pr);
      #1;
      hx = xhat_valid && xhat_ready;
      ha = alpha_valid && alpha_ready;
      hm = xmean_valid && xmean_ready;
      hh = xhatmean_valid && xhatmean_ready;
      lastx = hx && (idx == BLK - 1);
      chk("alpha_xfer", ha, lastx);
      chk("xmean_xfer", hm, lastx);
      chk("xhatmean_xfer", hh, lastx);
      if (hx) begin
        sb.push_back('{ref_pred(cur_t.a, cur_t.xm, cur_t.xhm, cur_x), cyc});
        idx = (idx + 1) % BLK;
        have_x = 0;
        if (idx == 0) have_t = 0;
        fired++;
        idle = 0;
      end else if (++idle > 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL input_timeout: got no xhat transfer for %0d cycles, expected one", idle);
        abort = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k = 0;
    xhat_valid = 0; alpha_valid = 0; xmean_valid = 0; xhatmean_valid = 0;
    prediction_ready = 1;
    while (sb.size() != 0 && k < 200) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    chk("drain_left", sb.size(), 0);
  endtask

  // Monitor: pops on every output transfer and watches hold-stability under stall.
  initial begin : monitor
    bit prev_stall = 0;
    logic [DW:0] prev_data = '0;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", prediction_valid, 1);
          chk("hold_data", prediction_data, prev_data);
        end
        if (prediction_valid && prediction_ready) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_output: got data %0h, expected no output", prediction_data);
          end else begin
            e = sb.pop_front();
            chk("prediction", prediction_data, e.data);
            if (lat_chk) chk("latency", cyc - e.cyc, 3);
          end
        end
        prev_stall = prediction_valid && !prediction_ready;
        prev_data  = prediction_data;
      end
    end
  end

  initial begin
    xhat_valid = 1; xmean_valid = 1; xhatmean_valid = 1; alpha_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_pvalid", prediction_valid, 0);
    chk("reset_pdata", prediction_data, 0);
    chk("reset_xhat_ready", xhat_ready, 0);
    chk("reset_alpha_ready", alpha_ready, 0);
    chk("reset_xmean_ready", xmean_ready, 0);
    chk("reset_xhatmean_ready", xhatmean_ready, 0);
    xhat_valid = 0; xmean_valid = 0; xhatmean_valid = 0; alpha_valid = 0;
    @(negedge clk);
    rst = 1;

    // Directed blocks: unity gain, half gain with negative d, both saturation rails.
    dir_t.push_back('{512, 2000, 900});
    dir_t.push_back('{256, 500, 1001});
    dir_t.push_back('{1023, 65535, 0});
    dir_t.push_back('{1023, 0, 65535});
    foreach (dir_t[i]) begin
      dir_x.push_back(i == 0 ? 1000 : i == 1 ? 900 : i == 2 ? 65535 : 0);
      for (int k = 1; k < BLK; k++) dir_x.push_back(rnd(65535));
    end
    lat_chk = 1;
    run(4 * BLK, 100, 100);
    drain();
    lat_chk = 0;

    // Random valids and backpressure across block boundaries.
    if (!abort) run(4 * BLK, 60, 50);

    // Reset mid-stream, then a fresh block must be framed from sample 0.
    if (!abort) begin
      run(100, 80, 50);
      rst = 0;
      #1;
      chk("midrst_pvalid", prediction_valid, 0);
      chk("midrst_pdata", prediction_data, 0);
      chk("midrst_xhat_ready", xhat_ready, 0);
      sb.delete();
      have_x = 0; have_t = 0; t_on = 0; idx = 0;
      xhat_valid = 0; alpha_valid = 0; xmean_valid = 0; xhatmean_valid = 0;
      repeat (3) @(negedge clk);
      rst = 1;
      run(BLK + 40, 80, 50);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
